// File: rtl/core_pkg.sv
// Shared definitions for the RV32 front end: fetch FSM states and fetch constants.
package core_pkg;

    // Fetch-stage FSM states.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0 -- what decode sees when IF/ID holds no live instruction.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Default PC after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential fetch advances by one 32-bit instruction.
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: {valid, pc, pc4, inst} with load, hold and flush-to-NOP.
// Flush has priority over load; with neither asserted the register holds.
// A flush clears valid and forces the NOP word but leaves pc/pc4 untouched.
module ifid_pipe_reg
    import core_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         flush,
    input  logic [N-1:0] pc_in,
    input  logic [N-1:0] pc4_in,
    input  logic [31:0]  inst_in,
    output logic         valid,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc4,
    output logic [31:0]  inst
);

    // Register update: reset, flush to NOP, load a new instruction, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            pc4   <= '0;
            inst  <= NOP_INST;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            pc4   <= pc4_in;
            inst  <= inst_in;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request
// and fills the IF/ID register. Handles hazard stalls and branch redirects.
//
// Memory handshake: imem_req is the request-valid, imem_ready the response-valid.
// A transfer (accept) happens in any cycle where both are high; imem_rdata is
// only looked at in that cycle. While imem_req=1 and imem_ready=0 the request
// stays up and imem_addr does not change, including across a redirect (the old
// request is drained and its response thrown away).
module if_fetch_stage
    import core_pkg::*;
#(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = N'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic         ifid_valid,
    output logic [N-1:0] ifid_pc,
    output logic [N-1:0] ifid_pc4,
    output logic [31:0]  ifid_inst
);

    fetch_state_e state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] drain_q, drain_d;
    logic         hold_valid_q, hold_valid_d;
    logic [N-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]  hold_inst_q, hold_inst_d;

    logic         accept;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] hold_pc_plus4;

    logic         ifid_load;
    logic         ifid_flush;
    logic [N-1:0] ifid_pc_in;
    logic [N-1:0] ifid_pc4_in;
    logic [31:0]  ifid_inst_in;

    // Request only in FETCH and DRAIN; DRAIN re-presents the pre-redirect address.
    assign imem_req      = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr     = (state_q == DRAIN) ? drain_q : pc_q;
    assign accept        = imem_req & imem_ready;
    assign pc_plus4      = pc_q + N'(PC_INC);
    assign hold_pc_plus4 = hold_pc_q + N'(PC_INC);

    // State register: FSM state, PC, drain address and the one-entry hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            drain_q      <= RESET_PC;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_inst_q  <= NOP_INST;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_q      <= drain_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
        end
    end

    // Next-state and IF/ID control; redirect outranks stall, stall outranks normal flow.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_d      = drain_q;
        hold_valid_d = hold_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        ifid_pc_in   = pc_q;
        ifid_pc4_in  = pc_plus4;
        ifid_inst_in = imem_rdata;

        if (redirect) begin
            ifid_flush   = 1'b1;
            hold_valid_d = 1'b0;
            pc_d         = redirect_pc;
            case (state_q)
                FETCH: begin
                    // An accepted word is simply dropped; an outstanding one must be drained.
                    if (!accept) begin
                        drain_d = pc_q;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // A drain that completes in this very cycle needs no further request.
                    if (accept) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                BOOT: state_d = FETCH;
                FETCH: begin
                    if (accept) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            hold_valid_d = 1'b1;
                            hold_pc_d    = pc_q;
                            hold_inst_d  = imem_rdata;
                            state_d      = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load    = hold_valid_q;
                        ifid_pc_in   = hold_pc_q;
                        ifid_pc4_in  = hold_pc_plus4;
                        ifid_inst_in = hold_inst_q;
                        hold_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
                DRAIN: begin
                    if (accept) state_d = FETCH;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    ifid_pipe_reg #(.N(N)) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .pc_in   (ifid_pc_in),
        .pc4_in  (ifid_pc4_in),
        .inst_in (ifid_inst_in),
        .valid   (ifid_valid),
        .pc      (ifid_pc),
        .pc4     (ifid_pc4),
        .inst    (ifid_inst)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle table, async reset checks and a
// randomized run against a program-order model of the instruction stream.
module tb_if_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_inst;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        stall;
        logic        ready;
        logic        redirect;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[21];

    // Memory model: every address holds its own address xor a fixed key.
    assign imem_rdata = imem_addr ^ KEY;

    if_fetch_stage #(.N(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (ready),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_inst   (ifid_inst)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic rd, input logic [31:0] rpc,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ep4, input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.ready = r; v.redirect = rd; v.rpc = rpc;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
        v.exp_pc = ep; v.exp_pc4 = ep4; v.exp_inst = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_req"},   {31'd0, imem_req},   32'd0);
        check({tag, " imem_addr"},  imem_addr,           32'h0);
        check({tag, " ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, " ifid_pc"},    ifid_pc,             32'h0);
        check({tag, " ifid_pc4"},   ifid_pc4,            32'h0);
        check({tag, " ifid_inst"},  ifid_inst,           NOP);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        prev_wait;
        logic [31:0] prev_addr;
        logic [31:0] exp_pc;
        int          consumed;

        // Each row: inputs for this cycle, outputs expected at the start of it.
        //          stall ready redir rpc            req addr           valid pc             pc4            inst
        vecs[0]  = mk(0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0,          NOP);
        vecs[1]  = mk(0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0,          NOP);
        vecs[2]  = mk(0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h4,          word_at(32'h0));
        vecs[3]  = mk(1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4,          32'h8,          word_at(32'h4));
        vecs[4]  = mk(1, 1, 0, 32'h0,          0, 32'hC,          1, 32'h4,          32'h8,          word_at(32'h4));
        vecs[5]  = mk(1, 1, 0, 32'h0,          0, 32'hC,          1, 32'h4,          32'h8,          word_at(32'h4));
        vecs[6]  = mk(0, 1, 0, 32'h0,          0, 32'hC,          1, 32'h4,          32'h8,          word_at(32'h4));
        vecs[7]  = mk(0, 1, 0, 32'h0,          1, 32'hC,          1, 32'h8,          32'hC,          word_at(32'h8));
        vecs[8]  = mk(0, 0, 0, 32'h0,          1, 32'h10,         1, 32'hC,          32'h10,         word_at(32'hC));
        vecs[9]  = mk(0, 0, 0, 32'h0,          1, 32'h10,         0, 32'hC,          32'h10,         NOP);
        vecs[10] = mk(0, 1, 0, 32'h0,          1, 32'h10,         0, 32'hC,          32'h10,         NOP);
        vecs[11] = mk(0, 0, 1, 32'h100,        1, 32'h14,         1, 32'h10,         32'h14,         word_at(32'h10));
        vecs[12] = mk(0, 0, 0, 32'h0,          1, 32'h14,         0, 32'h10,         32'h14,         NOP);
        vecs[13] = mk(0, 1, 0, 32'h0,          1, 32'h14,         0, 32'h10,         32'h14,         NOP);
        vecs[14] = mk(0, 1, 0, 32'h0,          1, 32'h100,        0, 32'h10,         32'h14,         NOP);
        vecs[15] = mk(1, 1, 1, 32'h200,        1, 32'h104,        1, 32'h100,        32'h104,        word_at(32'h100));
        vecs[16] = mk(1, 1, 0, 32'h0,          1, 32'h200,        0, 32'h100,        32'h104,        NOP);
        vecs[17] = mk(1, 1, 1, 32'hFFFF_FFFC,  0, 32'h204,        0, 32'h100,        32'h104,        NOP);
        vecs[18] = mk(0, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h100,        32'h104,        NOP);
        vecs[19] = mk(0, 1, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFFC,  32'h0,          word_at(32'hFFFF_FFFC));
        vecs[20] = mk(0, 1, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'h4,          word_at(32'h0));

        // Reset block.
        rst = 1'b1; stall = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed cycle table.
        for (int i = 0; i < 21; i++) begin
            check($sformatf("c%0d imem_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].exp_req});
            check($sformatf("c%0d imem_addr", i),  imem_addr,           vecs[i].exp_addr);
            check($sformatf("c%0d ifid_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("c%0d ifid_pc", i),    ifid_pc,             vecs[i].exp_pc);
            check($sformatf("c%0d ifid_pc4", i),   ifid_pc4,            vecs[i].exp_pc4);
            check($sformatf("c%0d ifid_inst", i),  ifid_inst,           vecs[i].exp_inst);
            stall       = vecs[i].stall;
            ready       = vecs[i].ready;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            step();
        end

        // Reset asserted mid-stream, away from any clock edge: outputs clear at once.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        stall = 1'b0; ready = 1'b1; redirect = 1'b0;
        step();
        check_reset_outputs("async_held");
        rst = 1'b0;

        // Randomized run. The model is the program-order stream: decode consumes
        // IF/ID when it is valid and neither stalled nor redirected, and must see
        // consecutive words from the last redirect target (or the reset PC).
        exp_q.delete();
        exp_q.push_back(32'h0);
        prev_wait = 1'b0;
        prev_addr = 32'h0;
        consumed  = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc == 0)
                check("rand boot imem_req", {31'd0, imem_req}, 32'd0);
            if (prev_wait) begin
                check($sformatf("rand%0d req held", cyc), {31'd0, imem_req}, 32'd1);
                check($sformatf("rand%0d addr held", cyc), imem_addr, prev_addr);
            end
            if (!ifid_valid)
                check($sformatf("rand%0d invalid nop", cyc), ifid_inst, NOP);

            stall       = ($urandom_range(0, 99) < 25);
            ready       = ($urandom_range(0, 99) < 70);
            redirect    = ($urandom_range(0, 99) < 6);
            redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);

            if (redirect) begin
                exp_q.delete();
                exp_q.push_back(redirect_pc);
            end else if (!stall && ifid_valid) begin
                exp_pc = exp_q.pop_front();
                check($sformatf("rand%0d ifid_pc", cyc),   ifid_pc,   exp_pc);
                check($sformatf("rand%0d ifid_pc4", cyc),  ifid_pc4,  exp_pc + 32'd4);
                check($sformatf("rand%0d ifid_inst", cyc), ifid_inst, word_at(exp_pc));
                // Resynchronise after a mismatch so one fault reports once, not forever.
                exp_q.push_back(((ifid_pc === exp_pc) ? exp_pc : ifid_pc) + 32'd4);
                consumed++;
            end
            prev_wait = imem_req && !ready;
            prev_addr = imem_addr;
            step();
        end
        check("rand forward progress", {31'd0, (consumed >= 150)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32 core. Owns the PC register and drives the instruction-memory request handshake.
- Fills the IF/ID pipeline register consumed by decode.
- Next-PC selection is internal: PC+4 or a redirect target from the branch resolution stage. The stage also supports stalls (hazard unit) and flushes (taken branch/jump).

Parameters:
- N, 32, address/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall: hold the PC and IF/ID.
- redirect  in  1  taken branch/jump: flush and refetch.
- redirect_pc  in  N  redirect target address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  N  fetch address. Held stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory response valid this cycle; imem_rdata is valid when high.
- imem_rdata  in  32  fetched instruction word.
- ifid_valid  out  1  IF/ID contains a live instruction.
- ifid_pc  out  N  PC of the IF/ID instruction.
- ifid_pc4  out  N  ifid_pc + 4.
- ifid_inst  out  32  instruction word; NOP when invalid.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=BOOT, hold buffer empty.
  - ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_inst=32'h0000_0013 (NOP).
  - imem_req=0; imem_addr=RESET_PC.
- States: BOOT, FETCH, HOLD, DRAIN. imem_req=1 in FETCH and DRAIN only.
- Addresses: imem_addr=pc in FETCH and HOLD; imem_addr=drain_addr in DRAIN.
- accept = imem_req & imem_ready (one-cycle response, or wait states while ready=0).
- BOOT: unconditionally goes to FETCH next cycle. Used to guarantee imem_req=0 in the first post-reset cycle.
- Priority in every state: rst > redirect > stall > normal.
- FETCH, no redirect:
  - accept & !stall: IF/ID <= {1, pc, pc+4, imem_rdata}; pc <= pc+4; stay FETCH.
  - accept & stall: word goes into the one-entry hold buffer {pc, rdata}; pc <= pc+4; IF/ID unchanged; go to HOLD.
  - !accept & !stall: ifid_valid <= 0 (bubble); request stays outstanding at the same address.
  - !accept & stall: IF/ID unchanged; request stays outstanding.
- HOLD (imem_req=0):
  - stall=1: hold everything.
  - stall=0: IF/ID <= hold buffer (valid=1); buffer cleared; go to FETCH.
- Redirect (any state):
  - ifid_valid <= 0, ifid_inst <= NOP; hold buffer cleared.
  - pc <= redirect_pc; stall ignored that cycle.
- Redirect in FETCH with request outstanding and no accept:
  - drain_addr <= current pc; go to DRAIN.
  - DRAIN holds imem_req=1 at drain_addr until accept. The response is discarded, then the stage goes to FETCH at the new pc.
- Redirect in FETCH with accept in the same cycle: response discarded; stay FETCH at redirect_pc.
- Redirect in DRAIN: pc <= newest redirect_pc; stay DRAIN; the drain address is unchanged.
- Redirect in HOLD or BOOT: go to FETCH at redirect_pc.
- In DRAIN, IF/ID stays invalid regardless of stall.
- Arithmetic: pc+4 is modulo 2^N; wrap from 32'hFFFF_FFFC to 0 is silent.
- redirect_pc is taken verbatim; bits [1:0] are not checked.
- Latency: an instruction accepted in cycle t, with stall=0, is visible on the IF/ID outputs in cycle t+1.
- Sustained throughput with zero-wait memory: one instruction per cycle.
- Reset asserted mid-request or in DRAIN: all state returns to reset values immediately. Any late imem_ready after reset is ignored until FETCH.

Decomposition:
- Shared package core_pkg:
  - fetch state enum (BOOT, FETCH, HOLD, DRAIN);
  - NOP_INST = 32'h0000_0013;
  - default RESET_PC;
  - PC increment constant 4.
- One natural sub-module: ifid_pipe_reg. It holds {valid, pc, pc4, inst} with load, hold, and flush-to-NOP controls, and its own async reset.

Test Plan:
- Reset then run with ready=1 every cycle, rdata=addr^32'hA5A5_0000:
  - imem_req=0 in the cycle after reset release;
  - then ifid_pc = 0, 4, 8, … on consecutive cycles, with ifid_inst matching.
- Stall for 3 cycles while ready=1 at pc=8:
  - word@8 captured into the hold buffer; pc=12; imem_req=0 during stall; IF/ID holds the word@4 entry.
  - On release, ifid_pc=8 with the correct word, then 12.
- Memory wait states (ready=0 for 2 cycles at pc=16): imem_addr stays 16; ifid_valid=0 for those cycles; then ifid_pc=16.
- Redirect to 32'h100 while a request at 20 is outstanding with ready low:
  - DRAIN state; imem_addr stays 20 until ready; the word@20 is never in IF/ID;
  - the next request is at 0x100, and ifid_pc=0x100 follows.
- Redirect and stall asserted in the same cycle: ifid_valid=0 and ifid_inst=NOP next cycle; pc=redirect_pc; the hold buffer is empty.
- redirect_pc=32'hFFFF_FFFC: next fetch is at 0, ifid_pc4=0 for that instruction. Then assert rst mid-stream: outputs return to reset values asynchronously.
